// File: rtl/link_upstream_credit_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : link_pkg
// Brief    : Shared types, default constants and index helpers for the
//            upstream credit serializer.
// Revision : 1.0
// ============================================================================
package link_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int c_DEF_CHANNELS         = 2;
    localparam int c_DEF_CH_WIDTH         = 8;
    localparam int c_DEF_RATIO            = 4;
    localparam int c_DEF_CREDITS          = 16;
    localparam int c_DEF_TOKEN_DECIMATION = 4;

    // Width of a counter that must represent 0..credits inclusive.
    function automatic int crw_f(input int credits);
        return $clog2(credits + 1);
    endfunction

    // LSB of the slice carried by channel ch during beat number beat.
    function automatic int beat_lsb_f(input int beat, input int ch,
                                      input int channels, input int ch_width);
        return (beat * channels + ch) * ch_width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/link_upstream_credit_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : link_upstream_credit_serializer_if
// Brief    : Core-side handshake, io channel bus and status bundle.
// Revision : 1.0
// ============================================================================
interface link_upstream_credit_serializer_if
    import link_pkg::*;
#(
    parameter int CHANNELS = c_DEF_CHANNELS,
    parameter int CH_WIDTH = c_DEF_CH_WIDTH,
    parameter int RATIO    = c_DEF_RATIO,
    parameter int CREDITS  = c_DEF_CREDITS
) ();
    localparam int CW  = CHANNELS * CH_WIDTH * RATIO;
    localparam int CRW = crw_f(CREDITS);

    logic                         core_valid_i;
    logic [CW-1:0]                core_data_i;
    logic                         core_ready_o;
    logic [CHANNELS-1:0]          io_valid_o;
    logic [CHANNELS*CH_WIDTH-1:0] io_data_o;
    logic [CHANNELS-1:0]          io_token_i;
    logic [CHANNELS*CRW-1:0]      credit_o;
    logic [15:0]                  sent_cnt_o;
    logic                         token_overflow_o;

    // Environment side: produces words and tokens, observes the link.
    modport master (
        output core_valid_i, core_data_i, io_token_i,
        input  core_ready_o, io_valid_o, io_data_o, credit_o,
               sent_cnt_o, token_overflow_o
    );

    // Serializer side.
    modport slave (
        input  core_valid_i, core_data_i, io_token_i,
        output core_ready_o, io_valid_o, io_data_o, credit_o,
               sent_cnt_o, token_overflow_o
    );
endinterface
`default_nettype wire

// File: rtl/link_upstream_credit_serializer_credit_counter.sv
`default_nettype none
// ============================================================================
// Module   : link_credit_counter
// Brief    : One channel's credit pool: decrement per flit, add a decimated
//            batch per token, saturate at CREDITS and flag the overflow.
// Revision : 1.0
// ============================================================================
module link_credit_counter
    import link_pkg::*;
#(
    parameter int CREDITS          = c_DEF_CREDITS,
    parameter int TOKEN_DECIMATION = c_DEF_TOKEN_DECIMATION,
    parameter int CRW              = crw_f(CREDITS)
) (
    input  wire logic           clk,
    input  wire logic           rst,
    input  wire logic           dec_i,
    input  wire logic           tok_i,
    output logic [CRW-1:0]      credit_o,
    output logic                nonzero_o,
    output logic                overflow_o
);
    // Headroom so credit + TOKEN_DECIMATION never wraps before the compare.
    localparam int EW = CRW + $clog2(TOKEN_DECIMATION + 1) + 1;

    logic [CRW-1:0] r_credit;
    logic [EW-1:0]  w_add;
    logic [EW-1:0]  w_sum;
    logic [CRW-1:0] w_credit_nxt;
    logic           w_over;

    always_comb begin
        w_add        = tok_i ? EW'(TOKEN_DECIMATION) : '0;
        w_sum        = EW'(r_credit) + w_add - EW'(dec_i);
        w_over       = w_sum > EW'(CREDITS);
        w_credit_nxt = w_over ? CRW'(CREDITS) : w_sum[CRW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_credit <= CRW'(CREDITS);
        end else begin
            r_credit <= w_credit_nxt;
        end
    end

    assign credit_o   = r_credit;
    assign nonzero_o  = (r_credit != '0);
    assign overflow_o = w_over;

endmodule
`default_nettype wire

// File: rtl/link_upstream_credit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : link_upstream_credit_serializer
// Brief    : Serialises wide core words over RATIO lockstep beats onto
//            CHANNELS credit-controlled output channels.
// Revision : 1.0
// ============================================================================
module link_upstream_credit_serializer
    import link_pkg::*;
#(
    parameter int CHANNELS         = c_DEF_CHANNELS,
    parameter int CH_WIDTH         = c_DEF_CH_WIDTH,
    parameter int RATIO            = c_DEF_RATIO,
    parameter int CREDITS          = c_DEF_CREDITS,
    parameter int TOKEN_DECIMATION = c_DEF_TOKEN_DECIMATION
) (
    input  wire logic                      clk,
    input  wire logic                      rst,
    link_upstream_credit_serializer_if.slave bus
);
    localparam int CW  = CHANNELS * CH_WIDTH * RATIO;
    localparam int IOW = CHANNELS * CH_WIDTH;
    localparam int CRW = crw_f(CREDITS);
    localparam int BW  = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int IW  = (CW > 1) ? $clog2(CW) : 1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [BW-1:0]       r_beat;
    logic [BW-1:0]       w_beat_nxt;
    logic [CW-1:0]       r_word;
    logic [CHANNELS-1:0] r_io_valid;
    logic [IOW-1:0]      r_io_data;
    logic [15:0]         r_sent;
    logic                r_ovf;

    logic [CHANNELS-1:0] w_nonzero;
    logic [CHANNELS-1:0] w_ovf;
    logic [IOW-1:0]      w_beat_data;
    logic                w_fire;
    logic                w_last;
    logic                w_ready;
    logic                w_hs;

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
            link_credit_counter #(
                .CREDITS          (CREDITS),
                .TOKEN_DECIMATION (TOKEN_DECIMATION),
                .CRW              (CRW)
            ) u_credit (
                .clk        (clk),
                .rst        (rst),
                .dec_i      (w_fire),
                .tok_i      (bus.io_token_i[c]),
                .credit_o   (bus.credit_o[c*CRW +: CRW]),
                .nonzero_o  (w_nonzero[c]),
                .overflow_o (w_ovf[c])
            );

            assign w_beat_data[c*CH_WIDTH +: CH_WIDTH] =
                r_word[IW'(beat_lsb_f(int'(r_beat), c, CHANNELS, CH_WIDTH)) +: CH_WIDTH];
        end
    endgenerate

    // Lockstep: a single empty channel stalls every channel.
    always_comb begin
        w_fire  = (r_state == SEND) && (&w_nonzero);
        w_last  = (r_beat == BW'(RATIO - 1));
        w_ready = (r_state == IDLE) || (w_fire && w_last);
        w_hs    = bus.core_valid_i && w_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_beat  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        case (r_state)
            IDLE: begin
                if (w_hs) begin
                    w_state_nxt = SEND;
                    w_beat_nxt  = '0;
                end
            end
            SEND: begin
                if (w_fire) begin
                    if (w_last) begin
                        w_state_nxt = w_hs ? SEND : IDLE;
                        w_beat_nxt  = '0;
                    end else begin
                        w_beat_nxt  = r_beat + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_beat_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_hs) begin
            r_word <= bus.core_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_io_valid <= '0;
            r_io_data  <= '0;
            r_sent     <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_ovf <= r_ovf | (|w_ovf);
            if (w_fire) begin
                r_io_valid <= '1;
                r_io_data  <= w_beat_data;
                r_sent     <= r_sent + 16'd1;
            end else begin
                r_io_valid <= '0;
            end
        end
    end

    assign bus.core_ready_o     = w_ready;
    assign bus.io_valid_o       = r_io_valid;
    assign bus.io_data_o        = r_io_data;
    assign bus.sent_cnt_o       = r_sent;
    assign bus.token_overflow_o = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_link_upstream_credit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_link_upstream_credit_serializer
// Brief    : Randomised bench against a flit-queue / credit-pool model.
// Revision : 1.0
// ============================================================================
module tb_link_upstream_credit_serializer;
    import link_pkg::*;

    localparam int CH  = 2;
    localparam int CHW = 8;
    localparam int R   = 4;
    localparam int CR  = 16;
    localparam int TD  = 4;
    localparam int CW  = CH * CHW * R;
    localparam int IOW = CH * CHW;
    localparam int CRW = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    link_upstream_credit_serializer_if #(
        .CHANNELS (CH), .CH_WIDTH (CHW), .RATIO (R), .CREDITS (CR)
    ) bus ();

    link_upstream_credit_serializer #(
        .CHANNELS (CH), .CH_WIDTH (CHW), .RATIO (R), .CREDITS (CR),
        .TOKEN_DECIMATION (TD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Model: pending flits of the word in flight, credit pools, counters.
    logic [IOW-1:0] m_q[$];
    int             m_cred[CH];
    bit             m_ovf;
    logic [15:0]    m_sent;
    logic [CH-1:0]  m_vexp;
    logic [IOW-1:0] m_dexp;
    int             n_chk;
    int             n_err;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        for (int c = 0; c < CH; c++) m_cred[c] = CR;
        m_ovf  = 1'b0;
        m_sent = '0;
        m_vexp = '0;
        m_dexp = '0;
    endtask

    // One clock: compare outputs, drive the next inputs, advance the model.
    task automatic step(input bit r, input bit v, input logic [CW-1:0] d, input logic [CH-1:0] tok);
        bit all_pos;
        bit exp_ready;
        bit fire;
        bit hs;
        int nc;
        @(negedge clk);
        all_pos = 1'b1;
        for (int c = 0; c < CH; c++) if (m_cred[c] == 0) all_pos = 1'b0;
        exp_ready = (m_q.size() == 0) || (m_q.size() == 1 && all_pos);
        for (int c = 0; c < CH; c++)
            chk_eq($sformatf("credit%0d", c), 64'(bus.credit_o[c*CRW +: CRW]), 64'(m_cred[c]));
        chk_eq("overflow", 64'(bus.token_overflow_o), 64'(m_ovf));
        chk_eq("sent_cnt", 64'(bus.sent_cnt_o), 64'(m_sent));
        chk_eq("io_valid", 64'(bus.io_valid_o), 64'(m_vexp));
        chk_eq("io_data",  64'(bus.io_data_o),  64'(m_dexp));
        chk_eq("ready",    64'(bus.core_ready_o), 64'(exp_ready));

        rst              = r;
        bus.core_valid_i = v;
        bus.core_data_i  = d;
        bus.io_token_i   = tok;

        if (r) begin
            model_reset();
        end else begin
            fire = (m_q.size() > 0) && all_pos;
            hs   = v && exp_ready;
            if (fire) begin
                m_dexp = m_q.pop_front();
                m_vexp = '1;
                m_sent = m_sent + 16'd1;
            end else begin
                m_vexp = '0;
            end
            for (int c = 0; c < CH; c++) begin
                nc = m_cred[c] - (fire ? 1 : 0) + (tok[c] ? TD : 0);
                if (nc > CR) begin
                    nc    = CR;
                    m_ovf = 1'b1;
                end
                m_cred[c] = nc;
            end
            if (hs) for (int b = 0; b < R; b++) m_q.push_back(d[b*IOW +: IOW]);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst              = 1'b1;
        bus.core_valid_i = 1'b0;
        bus.core_data_i  = '0;
        bus.io_token_i   = '0;
        model_reset();
        repeat (2) @(posedge clk);
        step(1'b1, 1'b0, '0, '0);

        // Single word, then drain.
        step(1'b0, 1'b1, 64'h0706050403020100, '0);
        idle(6);

        // Back-to-back words with no tokens until every pool is empty.
        for (int i = 0; i < 24; i++) step(1'b0, 1'b1, {$urandom, $urandom}, '0);
        step(1'b0, 1'b0, '0, 2'b01);
        idle(2);
        step(1'b0, 1'b0, '0, 2'b10);
        idle(6);

        // Saturation from a full pool.
        step(1'b1, 1'b0, '0, '0);
        step(1'b0, 1'b0, '0, 2'b01);
        idle(3);

        // Reset in the middle of a word, then a fresh word.
        step(1'b1, 1'b0, '0, '0);
        step(1'b0, 1'b1, {$urandom, $urandom}, '0);
        idle(2);
        step(1'b1, 1'b0, '0, '0);
        step(1'b0, 1'b1, {$urandom, $urandom}, '0);
        idle(6);

        // Random traffic with phases of scarce and plentiful tokens.
        for (int i = 0; i < 3000; i++) begin
            int k;
            logic [CH-1:0] tok;
            k = (i / 500) % 3;
            for (int c = 0; c < CH; c++)
                tok[c] = ($urandom_range(0, 15) < (k == 0 ? 1 : (k == 1 ? 3 : 8)));
            step(($urandom_range(0, 599) == 0), ($urandom_range(0, 3) != 0),
                 {$urandom, $urandom}, tok);
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
